// File: rtl/sdram_load_arb_if.sv
// Bundle of the loader, CPU and SDRAM client signals around sdram_load_arb.
// slave: the arbiter's view. master: the surrounding sources and controller.
interface sdram_load_arb_if;
   // ioctl ROM loader
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [15:0] ioctl_dout;
   logic        ioctl_wait;
   // CPU bus
   logic        cpu_req;
   logic        cpu_we;
   logic [24:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [1:0]  cpu_be;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   // SDRAM client port
   logic        mem_req;
   logic        mem_we;
   logic [24:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [1:0]  mem_be;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   // load status
   logic [23:0] load_words;
   logic        load_done;
   logic        load_err;

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      output ioctl_wait,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
      output cpu_ack, cpu_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata,
      output load_words, load_done, load_err
   );

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      input  ioctl_wait,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
      input  cpu_ack, cpu_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata,
      input  load_words, load_done, load_err
   );
endinterface

// File: rtl/sdram_load_arb.sv
// Shares the single SDRAM client port between the HPS ROM loader and the CPU.
// Loader words are buffered one deep (ioctl_wait = buffer full) and take priority
// over the CPU whenever the port is idle; the CPU is locked out during a download.
module sdram_load_arb #(
   parameter logic [24:0] ROM_BASE_A = 25'h0000000,
   parameter logic [24:0] ROM_BYTES  = 25'h0100000,
   parameter bit          SWAP_BYTES = 1'b1
) (
   input logic             clk_sys,
   input logic             reset_n,
   sdram_load_arb_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StLoad, StCpu} state_e;

   state_e      state_q;
   logic        pend_q;
   logic [23:0] ld_addr_q;   // word address, byte offset bit 0 dropped
   logic [15:0] ld_data_q;
   logic        dl_q;
   logic        load_done_q;
   logic        load_err_q;
   logic [23:0] load_words_q;

   logic        mem_req_q;
   logic        mem_we_q;
   logic [24:0] mem_addr_q;
   logic [15:0] mem_wdata_q;
   logic [1:0]  mem_be_q;
   logic        cpu_ack_q;
   logic [15:0] cpu_rdata_q;

   logic        wr_hit;
   logic        wr_accept;
   logic        wr_overrun;
   logic        dl_rise;
   logic        load_fin;
   logic [15:0] dout_sw;
   logic [24:0] cpu_addr_even;

   assign wr_hit     = bus.ioctl_wr & bus.ioctl_download & (bus.ioctl_index == 8'h00) &
                       (bus.ioctl_addr < ROM_BYTES);
   assign wr_accept  = wr_hit & ~pend_q;
   // Any strobe while the buffer is full is lost, whatever its target.
   assign wr_overrun = bus.ioctl_wr & pend_q;
   assign dl_rise    = bus.ioctl_download & ~dl_q;
   assign load_fin   = (state_q == StLoad) & bus.mem_ack;
   assign dout_sw    = SWAP_BYTES ? {bus.ioctl_dout[7:0], bus.ioctl_dout[15:8]}
                                  : bus.ioctl_dout;
   assign cpu_addr_even = bus.cpu_addr & ~25'h1;

   // Loader word buffer, download edge tracking and load statistics.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         pend_q       <= 1'b0;
         ld_addr_q    <= '0;
         ld_data_q    <= '0;
         dl_q         <= 1'b0;
         load_done_q  <= 1'b0;
         load_err_q   <= 1'b0;
         load_words_q <= '0;
      end else begin
         dl_q        <= bus.ioctl_download;
         load_done_q <= dl_q & ~bus.ioctl_download;

         if (wr_accept) begin
            pend_q    <= 1'b1;
            ld_addr_q <= bus.ioctl_addr[24:1];
            ld_data_q <= dout_sw;
         end else if (load_fin) begin
            pend_q <= 1'b0;
         end

         if (dl_rise) begin
            load_words_q <= '0;
         end else if (load_fin && load_words_q != 24'hFFFFFF) begin
            load_words_q <= load_words_q + 24'd1;
         end

         if (wr_overrun) begin
            load_err_q <= 1'b1;
         end else if (dl_rise) begin
            load_err_q <= 1'b0;
         end
      end
   end

   // Port arbiter: grant in IDLE, hold the registered request until mem_ack.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
      end else begin
         cpu_ack_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pend_q) begin
                  state_q     <= StLoad;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_be_q    <= 2'b11;
                  mem_addr_q  <= ROM_BASE_A + {ld_addr_q, 1'b0};
                  mem_wdata_q <= ld_data_q;
               // cpu_req is still up during its ack cycle; only re-grant after that.
               end else if (bus.cpu_req && !bus.ioctl_download && !cpu_ack_q) begin
                  state_q     <= StCpu;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= bus.cpu_we;
                  mem_be_q    <= bus.cpu_we ? bus.cpu_be : 2'b11;
                  mem_addr_q  <= cpu_addr_even;
                  mem_wdata_q <= bus.cpu_wdata;
               end
            end
            StLoad: begin
               if (bus.mem_ack) begin
                  state_q   <= StIdle;
                  mem_req_q <= 1'b0;
               end
            end
            StCpu: begin
               if (bus.mem_ack) begin
                  state_q   <= StIdle;
                  mem_req_q <= 1'b0;
                  cpu_ack_q <= 1'b1;
                  if (!mem_we_q) begin
                     cpu_rdata_q <= bus.mem_rdata;
                  end
               end
            end
            default: begin
               state_q   <= StIdle;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ioctl_wait = pend_q;
   assign bus.cpu_ack    = cpu_ack_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_be     = mem_be_q;
   assign bus.load_words = load_words_q;
   assign bus.load_done  = load_done_q;
   assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_sdram_load_arb.sv
// Directed bench for sdram_load_arb with a small SDRAM responder that logs
// every acknowledged transfer.
module tb_sdram_load_arb;

   localparam logic [24:0] BASE = 25'h0040000;
   localparam logic [24:0] RBYTES = 25'h0100000;

   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;

   sdram_load_arb_if bus_if();

   sdram_load_arb #(
      .ROM_BASE_A (BASE),
      .ROM_BYTES  (RBYTES),
      .SWAP_BYTES (1'b1)
   ) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus_if.slave)
   );

   always #5 clk_sys = ~clk_sys;

   int n_tests = 0;
   int n_fail = 0;

   // responder state
   int          ack_delay = 1;
   int          req_cnt = 0;
   logic [15:0] rdata_val = 16'h0000;
   logic        spur_flag = 1'b0;
   logic        spur_seen = 1'b0;
   int          n_log = 0;
   logic        log_we    [0:31];
   logic [24:0] log_addr  [0:31];
   logic [15:0] log_wdata [0:31];
   logic [1:0]  log_be    [0:31];

   // SDRAM model: acks after ack_delay cycles of mem_req, logs the transfer.
   always begin
      @(posedge clk_sys);
      #1;
      bus_if.mem_ack = 1'b0;
      if (spur_flag != spur_seen) begin
         spur_seen = spur_flag;
         bus_if.mem_ack = 1'b1;
      end else if (bus_if.mem_req) begin
         req_cnt++;
         if (req_cnt >= ack_delay) begin
            bus_if.mem_ack   = 1'b1;
            bus_if.mem_rdata = rdata_val;
            if (n_log < 32) begin
               log_we[n_log]    = bus_if.mem_we;
               log_addr[n_log]  = bus_if.mem_addr;
               log_wdata[n_log] = bus_if.mem_wdata;
               log_be[n_log]    = bus_if.mem_be;
            end
            n_log++;
            req_cnt = 0;
         end
      end else begin
         req_cnt = 0;
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #2;
   endtask

   task automatic ioctl_write(input logic [24:0] a, input logic [15:0] d);
      bus_if.ioctl_addr = a;
      bus_if.ioctl_dout = d;
      bus_if.ioctl_wr   = 1'b1;
      tick();
      bus_if.ioctl_wr   = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int k;
      for (k = 0; k < max_cyc; k++) begin
         tick();
         if (!bus_if.ioctl_wait && !bus_if.mem_req) break;
      end
      if (k == max_cyc) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_idle timeout: wait=%0b req=%0b, required 0/0",
                  bus_if.ioctl_wait, bus_if.mem_req);
      end
   endtask

   task automatic test_reset();
      bus_if.ioctl_download = 0; bus_if.ioctl_index = 0; bus_if.ioctl_wr = 0;
      bus_if.ioctl_addr = 0; bus_if.ioctl_dout = 0;
      bus_if.cpu_req = 0; bus_if.cpu_we = 0; bus_if.cpu_addr = 0;
      bus_if.cpu_wdata = 0; bus_if.cpu_be = 0; bus_if.mem_rdata = 0;
      reset_n = 1'b0;
      tick(); tick();
      n_tests++;
      if ({bus_if.mem_req, bus_if.mem_we, bus_if.ioctl_wait, bus_if.cpu_ack} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: req/we/wait/ack=%b required 0000",
                  {bus_if.mem_req, bus_if.mem_we, bus_if.ioctl_wait, bus_if.cpu_ack});
      end
      n_tests++;
      if (bus_if.mem_addr !== 25'h0 || bus_if.mem_wdata !== 16'h0 || bus_if.mem_be !== 2'b0) begin
         n_fail++;
         $display("FAIL reset_mem: addr=%h wdata=%h be=%b required 0", bus_if.mem_addr,
                  bus_if.mem_wdata, bus_if.mem_be);
      end
      n_tests++;
      if (bus_if.cpu_rdata !== 16'h0 || bus_if.load_words !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_data: rdata=%h words=%h required 0", bus_if.cpu_rdata,
                  bus_if.load_words);
      end
      n_tests++;
      if (bus_if.load_err !== 1'b0 || bus_if.load_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: err=%b done=%b required 0", bus_if.load_err,
                  bus_if.load_done);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_download();
      int n0;
      int dones;
      ack_delay = 1;
      bus_if.ioctl_download = 1'b1;
      tick(); tick();
      n0 = n_log;
      ioctl_write(25'h0, 16'h1234);
      wait_idle(20);
      ioctl_write(25'h2, 16'hABCD);
      wait_idle(20);
      bus_if.ioctl_download = 1'b0;
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus_if.load_done) dones++;
      end
      n_tests++;
      if (n_log !== n0 + 2) begin
         n_fail++;
         $display("FAIL dl_count: writes=%0d required %0d", n_log - n0, 2);
      end else begin
         n_tests++;
         if (log_wdata[n0] !== 16'h3412 || log_addr[n0] !== BASE) begin
            n_fail++;
            $display("FAIL dl_word0: data=%h addr=%h required 3412 %h", log_wdata[n0],
                     log_addr[n0], BASE);
         end
         n_tests++;
         if (log_wdata[n0+1] !== 16'hCDAB || log_addr[n0+1] !== BASE + 25'h2) begin
            n_fail++;
            $display("FAIL dl_word1: data=%h addr=%h required cdab %h", log_wdata[n0+1],
                     log_addr[n0+1], BASE + 25'h2);
         end
         n_tests++;
         if (log_we[n0] !== 1'b1 || log_be[n0] !== 2'b11) begin
            n_fail++;
            $display("FAIL dl_we_be: we=%b be=%b required 1 11", log_we[n0], log_be[n0]);
         end
      end
      n_tests++;
      if (bus_if.load_words !== 24'd2) begin
         n_fail++;
         $display("FAIL dl_words: load_words=%0d required 2", bus_if.load_words);
      end
      n_tests++;
      if (dones !== 1) begin
         n_fail++;
         $display("FAIL dl_done: pulses=%0d required 1", dones);
      end
   endtask

   task automatic test_wait_flow();
      int highs;
      bit first_hi;
      ack_delay = 5;
      bus_if.ioctl_download = 1'b1;
      tick(); tick();
      ioctl_write(25'h10, 16'h0001);
      first_hi = bus_if.ioctl_wait;
      highs = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus_if.ioctl_wait) highs++;
         tick();
      end
      // captured at edge E1, request from E2, ack cycle E6..E7, pend clears at E7
      n_tests++;
      if (first_hi !== 1'b1) begin
         n_fail++;
         $display("FAIL wait_rise: wait=%b required 1", first_hi);
      end
      n_tests++;
      if (highs !== 6) begin
         n_fail++;
         $display("FAIL wait_len: high cycles=%0d required 6", highs);
      end
      n_tests++;
      if (bus_if.ioctl_wait !== 1'b0 || bus_if.load_words !== 24'd1) begin
         n_fail++;
         $display("FAIL wait_end: wait=%b words=%0d required 0 1", bus_if.ioctl_wait,
                  bus_if.load_words);
      end
   endtask

   task automatic test_overrun();
      int n0;
      ack_delay = 4;
      bus_if.ioctl_download = 1'b0;
      tick();
      bus_if.ioctl_download = 1'b1;
      tick(); tick();
      n0 = n_log;
      ioctl_write(25'h20, 16'h1122);
      ioctl_write(25'h22, 16'h3344);
      wait_idle(30);
      tick(); tick();
      n_tests++;
      if (n_log !== n0 + 1) begin
         n_fail++;
         $display("FAIL ovr_writes: writes=%0d required 1", n_log - n0);
      end else begin
         n_tests++;
         if (log_wdata[n0] !== 16'h2211 || log_addr[n0] !== BASE + 25'h20) begin
            n_fail++;
            $display("FAIL ovr_word: data=%h addr=%h required 2211 %h", log_wdata[n0],
                     log_addr[n0], BASE + 25'h20);
         end
      end
      n_tests++;
      if (bus_if.load_err !== 1'b1 || bus_if.load_words !== 24'd1) begin
         n_fail++;
         $display("FAIL ovr_err: err=%b words=%0d required 1 1", bus_if.load_err,
                  bus_if.load_words);
      end
      bus_if.ioctl_download = 1'b0;
      tick();
      bus_if.ioctl_download = 1'b1;
      tick(); tick();
      n_tests++;
      if (bus_if.load_err !== 1'b0 || bus_if.load_words !== 24'd0) begin
         n_fail++;
         $display("FAIL ovr_clear: err=%b words=%0d required 0 0", bus_if.load_err,
                  bus_if.load_words);
      end
   endtask

   task automatic test_cpu_blocked();
      int grants;
      int n0;
      bit seen;
      logic prev_mack;
      ack_delay = 1;
      rdata_val = 16'hBEEF;
      n0 = n_log;
      bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 25'h0200000; bus_if.cpu_be = 2'b00;
      bus_if.cpu_req = 1'b1;
      grants = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus_if.mem_req) grants++;
      end
      n_tests++;
      if (grants !== 0) begin
         n_fail++;
         $display("FAIL cpu_locked: req cycles=%0d required 0", grants);
      end
      bus_if.ioctl_download = 1'b0;
      seen = 1'b0;
      prev_mack = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus_if.cpu_ack) begin
            seen = 1'b1;
            break;
         end
         prev_mack = bus_if.mem_ack;
      end
      bus_if.cpu_req = 1'b0;
      n_tests++;
      if (!seen || prev_mack !== 1'b1) begin
         n_fail++;
         $display("FAIL cpu_ack_lat: ack seen=%b mem_ack before=%b required 1 1", seen,
                  prev_mack);
      end
      n_tests++;
      if (bus_if.cpu_rdata !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL cpu_rdata: %h required beef", bus_if.cpu_rdata);
      end
      n_tests++;
      if (n_log < n0 + 1 || log_we[n0] !== 1'b0 || log_addr[n0] !== 25'h0200000 ||
          log_be[n0] !== 2'b11) begin
         n_fail++;
         $display("FAIL cpu_rd_cyc: n=%0d we=%b addr=%h be=%b required 1 0 0200000 11",
                  n_log - n0, log_we[n0], log_addr[n0], log_be[n0]);
      end
      tick();
      n_tests++;
      if (bus_if.cpu_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL cpu_ack_pulse: ack=%b required 0", bus_if.cpu_ack);
      end
      tick(); tick(); tick();
      n_tests++;
      if (n_log !== n0 + 1 || bus_if.cpu_rdata !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL cpu_once: transfers=%0d rdata=%h required 1 beef", n_log - n0,
                  bus_if.cpu_rdata);
      end
   endtask

   task automatic test_no_preempt();
      int n0;
      int k;
      bit seen;
      ack_delay = 4;
      n0 = n_log;
      bus_if.cpu_we = 1'b1; bus_if.cpu_addr = 25'h0000100; bus_if.cpu_wdata = 16'h5555;
      bus_if.cpu_be = 2'b01;
      bus_if.cpu_req = 1'b1;
      for (k = 0; k < 10; k++) begin
         tick();
         if (bus_if.mem_req) break;
      end
      n_tests++;
      if (k == 10) begin
         n_fail++;
         $display("FAIL np_grant: mem_req=%b required 1", bus_if.mem_req);
      end
      bus_if.ioctl_download = 1'b1;
      ioctl_write(25'h10, 16'h0102);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus_if.cpu_ack) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      bus_if.cpu_req = 1'b0;
      wait_idle(30);
      n_tests++;
      if (!seen || n_log !== n0 + 2) begin
         n_fail++;
         $display("FAIL np_count: ack=%b transfers=%0d required 1 2", seen, n_log - n0);
      end else begin
         n_tests++;
         if (log_we[n0] !== 1'b1 || log_addr[n0] !== 25'h100 || log_wdata[n0] !== 16'h5555 ||
             log_be[n0] !== 2'b01) begin
            n_fail++;
            $display("FAIL np_first: we=%b addr=%h data=%h be=%b required 1 0000100 5555 01",
                     log_we[n0], log_addr[n0], log_wdata[n0], log_be[n0]);
         end
         n_tests++;
         if (log_addr[n0+1] !== BASE + 25'h10 || log_wdata[n0+1] !== 16'h0201) begin
            n_fail++;
            $display("FAIL np_second: addr=%h data=%h required %h 0201", log_addr[n0+1],
                     log_wdata[n0+1], BASE + 25'h10);
         end
      end
      n0 = n_log;
      bus_if.ioctl_index = 8'h00;
      ioctl_write(RBYTES, 16'hDEAD);
      n_tests++;
      if (bus_if.ioctl_wait !== 1'b0) begin
         n_fail++;
         $display("FAIL np_oob_wait: wait=%b required 0", bus_if.ioctl_wait);
      end
      bus_if.ioctl_index = 8'h01;
      ioctl_write(25'h0, 16'hBEAD);
      n_tests++;
      if (bus_if.ioctl_wait !== 1'b0) begin
         n_fail++;
         $display("FAIL np_idx_wait: wait=%b required 0", bus_if.ioctl_wait);
      end
      bus_if.ioctl_index = 8'h00;
      for (int i = 0; i < 8; i++) tick();
      n_tests++;
      if (n_log !== n0 || bus_if.load_words !== 24'd1 || bus_if.load_err !== 1'b0) begin
         n_fail++;
         $display("FAIL np_ignored: transfers=%0d words=%0d err=%b required 0 1 0",
                  n_log - n0, bus_if.load_words, bus_if.load_err);
      end
   endtask

   task automatic test_reset_mid();
      int n0;
      int k;
      ack_delay = 100;
      n0 = n_log;
      ioctl_write(25'h30, 16'hAAAA);
      for (k = 0; k < 10; k++) begin
         tick();
         if (bus_if.mem_req) break;
      end
      n_tests++;
      if (bus_if.mem_req !== 1'b1 || bus_if.mem_we !== 1'b1) begin
         n_fail++;
         $display("FAIL rm_load: req=%b we=%b required 1 1", bus_if.mem_req, bus_if.mem_we);
      end
      reset_n = 1'b0;
      #1;
      n_tests++;
      if ({bus_if.mem_req, bus_if.mem_we, bus_if.ioctl_wait} !== 3'b000 ||
          bus_if.mem_addr !== 25'h0 || bus_if.mem_wdata !== 16'h0) begin
         n_fail++;
         $display("FAIL rm_async: req/we/wait=%b addr=%h data=%h required 000 0 0",
                  {bus_if.mem_req, bus_if.mem_we, bus_if.ioctl_wait}, bus_if.mem_addr,
                  bus_if.mem_wdata);
      end
      tick();
      reset_n = 1'b1;
      ack_delay = 1;
      spur_flag = ~spur_flag;
      for (int i = 0; i < 5; i++) tick();
      n_tests++;
      if (bus_if.mem_req !== 1'b0 || bus_if.ioctl_wait !== 1'b0 || n_log !== n0 ||
          bus_if.load_words !== 24'd0) begin
         n_fail++;
         $display("FAIL rm_after: req=%b wait=%b transfers=%0d words=%0d required 0 0 0 0",
                  bus_if.mem_req, bus_if.ioctl_wait, n_log - n0, bus_if.load_words);
      end
      ioctl_write(25'h41, 16'h7788);
      wait_idle(20);
      n_tests++;
      if (n_log !== n0 + 1 || log_addr[n0] !== BASE + 25'h40 || log_wdata[n0] !== 16'h8877 ||
          bus_if.load_words !== 24'd1) begin
         n_fail++;
         $display("FAIL rm_resume: n=%0d addr=%h data=%h words=%0d required 1 %h 8877 1",
                  n_log - n0, log_addr[n0], log_wdata[n0], bus_if.load_words, BASE + 25'h40);
      end
   endtask

   initial begin
      test_reset();
      test_download();
      test_wait_flow();
      test_overrun();
      test_cpu_blocked();
      test_no_preempt();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: sim time exceeded");
      $fatal(1, "timeout");
   end

endmodule
